w_stuff_nrzi: RTL and testbench

W_STUFF_NRZI -- requirements
Module: w_stuff_nrzi

---
 rtl/w_stuff_nrzi.sv | 101 ++++++++++
 tb/tb_w_stuff_nrzi.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/w_stuff_nrzi.sv
// NRZI encoder with USB-style bit stuffing: a 0 is inserted after six consecutive 1s.
// The line level register doubles as the registered serial output and idles at J (1).
module w_stuff_nrzi (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_in_valid,
    output logic       bit_in_ready,
    input  logic [1:0] p_type_in,
    output logic       bstr_out,
    output logic       bstr_out_ready,
    output logic [1:0] p_type_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        STUFF  = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       lvl;
    logic       lvl_nx;
    logic [2:0] ones;
    logic [2:0] ones_nx;
    logic       out_rdy_nx;
    logic [1:0] ptype_nx;
    logic       data_lvl;
    logic [2:0] ones_acc;

    // Upstream is stalled only while the stuffed 0 occupies the line slot.
    assign bit_in_ready = (state != STUFF) && !rst;
    assign bstr_out     = lvl;

    assign data_lvl = bit_in ? lvl : ~lvl;
    assign ones_acc = bit_in ? (ones + 3'd1) : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lvl            <= 1'b1;
            ones           <= 3'd0;
            bstr_out_ready <= 1'b0;
            p_type_out     <= 2'b00;
        end else begin
            state          <= state_nx;
            lvl            <= lvl_nx;
            ones           <= ones_nx;
            bstr_out_ready <= out_rdy_nx;
            p_type_out     <= ptype_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lvl_nx     = lvl;
        ones_nx    = ones;
        out_rdy_nx = 1'b0;
        ptype_nx   = p_type_out;
        case (state)
            IDLE: begin
                if (bit_in_valid) begin
                    ptype_nx   = p_type_in;
                    lvl_nx     = data_lvl;
                    ones_nx    = ones_acc;
                    out_rdy_nx = 1'b1;
                    state_nx   = ACTIVE;
                end else begin
                    lvl_nx  = 1'b1;
                    ones_nx = 3'd0;
                end
            end
            ACTIVE: begin
                if (bit_in_valid) begin
                    lvl_nx     = data_lvl;
                    ones_nx    = ones_acc;
                    out_rdy_nx = 1'b1;
                    state_nx   = (ones_acc == 3'd6) ? STUFF : ACTIVE;
                end else begin
                    // End of packet: line returns to J so the next packet starts clean.
                    lvl_nx   = 1'b1;
                    ones_nx  = 3'd0;
                    state_nx = IDLE;
                end
            end
            STUFF: begin
                lvl_nx     = ~lvl;
                ones_nx    = 3'd0;
                out_rdy_nx = 1'b1;
                state_nx   = ACTIVE;
            end
            default: begin
                lvl_nx   = 1'b1;
                ones_nx  = 3'd0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_w_stuff_nrzi.sv
// Directed bench for w_stuff_nrzi: a vector table of per-cycle expectations plus
// hand-written sequences for reset during stuffing and back-to-back packets.
module tb_w_stuff_nrzi;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_in_valid;
    logic       bit_in_ready;
    logic [1:0] p_type_in;
    logic       bstr_out;
    logic       bstr_out_ready;
    logic [1:0] p_type_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst_v;
        logic       valid;
        logic       bit_v;
        logic [1:0] pt;
        logic       exp_in_rdy;
        logic       exp_out;
        logic       exp_out_rdy;
        logic [1:0] exp_pt;
    } vec_t;

    vec_t vecs[$];

    w_stuff_nrzi dut (
        .clk            (clk),
        .rst            (rst),
        .bit_in         (bit_in),
        .bit_in_valid   (bit_in_valid),
        .bit_in_ready   (bit_in_ready),
        .p_type_in      (p_type_in),
        .bstr_out       (bstr_out),
        .bstr_out_ready (bstr_out_ready),
        .p_type_out     (p_type_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check the combinational ready.
    task automatic applyStimulus(input logic r, input logic v, input logic b,
                                 input logic [1:0] pt, input logic exp_in_rdy);
        @(negedge clk);
        rst          = r;
        bit_in_valid = v;
        bit_in       = b;
        p_type_in    = pt;
        #1;
        compare("bit_in_ready", {1'b0, bit_in_ready}, {1'b0, exp_in_rdy});
    endtask

    // Check the registered outputs just after the rising edge.
    task automatic checkOutput(input logic exp_out, input logic exp_out_rdy, input logic [1:0] exp_pt);
        @(posedge clk);
        #1;
        compare("bstr_out", {1'b0, bstr_out}, {1'b0, exp_out});
        compare("bstr_out_ready", {1'b0, bstr_out_ready}, {1'b0, exp_out_rdy});
        compare("p_type_out", p_type_out, exp_pt);
    endtask

    task automatic cycle(input logic r, input logic v, input logic b, input logic [1:0] pt,
                         input logic exp_in_rdy, input logic exp_out, input logic exp_out_rdy,
                         input logic [1:0] exp_pt);
        applyStimulus(r, v, b, pt, exp_in_rdy);
        checkOutput(exp_out, exp_out_rdy, exp_pt);
    endtask

    function automatic void addVec(input logic r, input logic v, input logic b, input logic [1:0] pt,
                                   input logic exp_in_rdy, input logic exp_out,
                                   input logic exp_out_rdy, input logic [1:0] exp_pt);
        vec_t x;
        x.rst_v       = r;
        x.valid       = v;
        x.bit_v       = b;
        x.pt          = pt;
        x.exp_in_rdy  = exp_in_rdy;
        x.exp_out     = exp_out;
        x.exp_out_rdy = exp_out_rdy;
        x.exp_pt      = exp_pt;
        vecs.push_back(x);
    endfunction

    initial begin
        logic [7:0] sync_bits;
        logic [7:0] sync_line;
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_in_valid = 1'b0;
        p_type_in    = 2'b00;

        // Reset state and an idle cycle
        addVec(1, 0, 0, 2'b00, 0, 1, 0, 2'b00);
        addVec(0, 0, 0, 2'b00, 1, 1, 0, 2'b00);

        // SYNC 00000001 with token type; line toggles on every 0 from J
        sync_bits = 8'b0000_0001;
        sync_line = 8'b0101_0100;
        for (int i = 0; i < 8; i++)
            addVec(0, 1, sync_bits[7-i], 2'b01, 1, sync_line[7-i], 1, 2'b01);
        addVec(0, 0, 0, 2'b00, 1, 1, 0, 2'b01);

        // Seven 1s: stuff after the sixth, upstream holds the seventh during the stall
        for (int i = 0; i < 6; i++)
            addVec(0, 1, 1, 2'b10, 1, 1, 1, 2'b10);
        addVec(0, 1, 1, 2'b10, 0, 0, 1, 2'b10);
        addVec(0, 1, 1, 2'b10, 1, 0, 1, 2'b10);
        addVec(0, 0, 0, 2'b00, 1, 1, 0, 2'b10);

        // 1x5, 0, 1x5: the 0 resets the run, so no stuff is inserted
        for (int i = 0; i < 5; i++)
            addVec(0, 1, 1, 2'b11, 1, 1, 1, 2'b11);
        addVec(0, 1, 0, 2'b11, 1, 0, 1, 2'b11);
        for (int i = 0; i < 5; i++)
            addVec(0, 1, 1, 2'b11, 1, 0, 1, 2'b11);
        addVec(0, 0, 0, 2'b00, 1, 1, 0, 2'b11);

        foreach (vecs[i])
            cycle(vecs[i].rst_v, vecs[i].valid, vecs[i].bit_v, vecs[i].pt, vecs[i].exp_in_rdy,
                  vecs[i].exp_out, vecs[i].exp_out_rdy, vecs[i].exp_pt);

        $display("[TB] packet ending in six 1s");
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 1, 2'b01, 1, 1, 1, 2'b01);
        cycle(0, 0, 0, 2'b00, 0, 0, 1, 2'b01);
        cycle(0, 0, 0, 2'b00, 1, 1, 0, 2'b01);
        cycle(0, 0, 0, 2'b00, 1, 1, 0, 2'b01);

        $display("[TB] reset during stuff");
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 1, 2'b10, 1, 1, 1, 2'b10);
        cycle(1, 1, 1, 2'b10, 0, 1, 0, 2'b00);
        cycle(0, 1, 0, 2'b11, 1, 0, 1, 2'b11);
        cycle(0, 1, 1, 2'b11, 1, 0, 1, 2'b11);
        cycle(1, 1, 0, 2'b11, 0, 1, 0, 2'b00);
        cycle(0, 0, 0, 2'b00, 1, 1, 0, 2'b00);

        $display("[TB] back-to-back packets");
        cycle(0, 1, 0, 2'b01, 1, 0, 1, 2'b01);
        cycle(0, 1, 0, 2'b01, 1, 1, 1, 2'b01);
        cycle(0, 1, 0, 2'b01, 1, 0, 1, 2'b01);
        cycle(0, 0, 0, 2'b00, 1, 1, 0, 2'b01);
        cycle(0, 1, 1, 2'b10, 1, 1, 1, 2'b10);
        cycle(0, 1, 0, 2'b11, 1, 0, 1, 2'b10);
        cycle(0, 0, 0, 2'b00, 1, 1, 0, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
